// File: rtl/avmm_responder_pkg.sv
// Shared types and constants for the SDRAM-window Avalon-MM responder.
package avmm_responder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STALL,
      ACK
   } state_t;

   localparam logic [31:0] BAD_READ = 32'hBAD0BAD0;

endpackage

// File: rtl/avmm_sdram_responder_read_resp_pipe.sv
// Fixed-latency read response pipeline: LATENCY register stages of {valid, data}.
// Each data stage only loads alongside its valid bit, so the output data holds between responses.
module read_resp_pipe #(
   parameter int LATENCY = 3,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   localparam int STAGES = LATENCY - 1;

   logic [STAGES:0]         vld_pipe;
   logic [STAGES:0][DW-1:0] dat_pipe;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_valid;
         if (in_valid) dat_pipe[0] <= in_data;
         for (int i = 1; i <= STAGES; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
         end
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign out_data  = dat_pipe[STAGES];

endmodule

// File: rtl/avmm_sdram_responder.sv
// Avalon-MM slave modelling an SDRAM-like target: per-command stalls, pipelined
// fixed-latency reads with bounded outstanding count, byte-enabled writes.
module avmm_sdram_responder
   import avmm_responder_pkg::*;
#(
   parameter int          ADDRESSWIDTH = 26,
   parameter int          DATAWIDTH    = 32,
   parameter int          MEM_WORDS    = 64,
   parameter logic [31:0] BASE_ADDR    = 32'h08000000,
   parameter int          READ_LATENCY = 3,
   parameter int          WAIT_CYCLES  = 1,
   parameter int          MAX_PENDING  = 4
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [ADDRESSWIDTH-1:0]            address,
   input  logic [DATAWIDTH-1:0]               writedata,
   input  logic [DATAWIDTH/8-1:0]             byteenable,
   input  logic                               write,
   input  logic                               read,
   output logic                               waitrequest,
   output logic [DATAWIDTH-1:0]               readdata,
   output logic                               readdatavalid,
   output logic                               err,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count
);

   localparam int BEW = DATAWIDTH / 8;
   localparam int IW  = $clog2(MEM_WORDS);
   localparam int PW  = $clog2(MAX_PENDING + 1);
   localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   // The master only drives ADDRESSWIDTH bits, so the window base is seen modulo that span.
   localparam logic [ADDRESSWIDTH-1:0] BASE_W = ADDRESSWIDTH'(BASE_ADDR);

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic                  any_req, rd_only, slot_ok;
   logic                  accept, acc_wr, acc_rd;
   logic [ADDRESSWIDTH:0] offset;
   logic                  in_range;
   logic [IW-1:0]         word_idx;
   logic [DATAWIDTH-1:0]  rd_word;
   logic                  unused_offset_bits;

   logic [DATAWIDTH-1:0]  mem [MEM_WORDS];

   assign any_req = read | write;
   assign rd_only = read & ~write;
   // Only a plain read consumes a response slot; read+write is treated as a write.
   assign slot_ok = ~rd_only | (pending_count < PW'(MAX_PENDING));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (any_req) begin
               cnt_nxt = CW'(WAIT_CYCLES);
               if (WAIT_CYCLES > 0) state_nxt = STALL;
               else                 state_nxt = slot_ok ? ACK : STALL;
            end
         end
         STALL: begin
            if (!any_req) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               if (cnt != '0) cnt_nxt = cnt - CW'(1);
               // Parks here at cnt==0 while the read gate is closed.
               if (cnt <= CW'(1) && slot_ok) state_nxt = ACK;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign waitrequest = (state != ACK);
   assign accept      = (state == ACK);
   assign acc_wr      = accept & write;
   assign acc_rd      = accept & read & ~write;

   assign offset   = {1'b0, address} - {1'b0, BASE_W};
   assign in_range = ~offset[ADDRESSWIDTH] && (offset[ADDRESSWIDTH-1:IW+2] == '0);
   assign word_idx = offset[IW+1:2];
   assign unused_offset_bits = ^offset[1:0];

   always_ff @(posedge clk) begin
      if (acc_wr && in_range) begin
         for (int b = 0; b < BEW; b++) begin
            if (byteenable[b]) mem[word_idx][b*8 +: 8] <= writedata[b*8 +: 8];
         end
      end
   end

   assign rd_word = in_range ? mem[word_idx] : DATAWIDTH'(BAD_READ);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err <= 1'b0;
      end else if (accept && ((read && write) || !in_range)) begin
         err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_count <= '0;
      end else begin
         case ({acc_rd, readdatavalid})
            2'b10:   pending_count <= pending_count + PW'(1);
            2'b01:   pending_count <= pending_count - PW'(1);
            default: pending_count <= pending_count;
         endcase
      end
   end

   read_resp_pipe #(
      .LATENCY (READ_LATENCY),
      .DW      (DATAWIDTH)
   ) u_resp_pipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (acc_rd),
      .in_data   (rd_word),
      .out_valid (readdatavalid),
      .out_data  (readdata)
   );

endmodule

// File: tb/tb_avmm_sdram_responder.sv
// Scoreboard bench: dut0 uses default timing, dut1 a long-latency/two-slot setup for back-pressure and reset.
module tb_avmm_sdram_responder;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   logic [1:0]        rst_n = 2'b00;
   logic [1:0]        rd = 2'b00, wr = 2'b00;
   logic [1:0][25:0]  addr = '0;
   logic [1:0][31:0]  wdata = '0;
   logic [1:0][3:0]   be = '0;

   logic        wreq0, wreq1, rdv0, rdv1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [2:0]  pc0;
   logic [1:0]  pc1;
   logic [1:0]  wreq, rdv, err;
   assign wreq = {wreq1, wreq0};
   assign rdv  = {rdv1, rdv0};
   assign err  = {err1, err0};

   avmm_sdram_responder #(.READ_LATENCY(3), .WAIT_CYCLES(1), .MAX_PENDING(4)) dut0 (
      .clk(clk), .reset_n(rst_n[0]), .address(addr[0]), .writedata(wdata[0]),
      .byteenable(be[0]), .write(wr[0]), .read(rd[0]), .waitrequest(wreq0),
      .readdata(rdata0), .readdatavalid(rdv0), .err(err0), .pending_count(pc0));

   avmm_sdram_responder #(.READ_LATENCY(8), .WAIT_CYCLES(1), .MAX_PENDING(2)) dut1 (
      .clk(clk), .reset_n(rst_n[1]), .address(addr[1]), .writedata(wdata[1]),
      .byteenable(be[1]), .write(wr[1]), .read(rd[1]), .waitrequest(wreq1),
      .readdata(rdata1), .readdatavalid(rdv1), .err(err1), .pending_count(pc1));

   exp_t        q0[$], q1[$];
   exp_t        e0, e1;
   int          n_tests = 0, n_fail = 0;
   int          rdv_cnt0 = 0, rdv_cnt1 = 0;
   int          max_pc1 = 0;
   bit          arm1 = 0;
   logic [31:0] first_rdv1 = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [25:0] wa(input logic [31:0] a);
      return a[25:0];
   endfunction

   // Monitor: pops the scoreboard whenever a response appears.
   always @(negedge clk) begin
      if (rst_n[0] && rdv0) begin
         rdv_cnt0++;
         if (q0.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rdv0: readdatavalid=1 with data %h, none outstanding", rdata0);
         end else begin
            e0 = q0.pop_front();
            check("rdata0", rdata0, e0.data);
            check("rdv0_cycle", cyc, e0.cyc);
         end
      end
      if (rst_n[1] && rdv1) begin
         rdv_cnt1++;
         if (arm1) begin first_rdv1 = cyc; arm1 = 0; end
         if (q1.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rdv1: readdatavalid=1 with data %h, none outstanding", rdata1);
         end else begin
            e1 = q1.pop_front();
            check("rdata1", rdata1, e1.data);
            check("rdv1_cycle", cyc, e1.cyc);
         end
      end
      if (int'(pc1) > max_pc1) max_pc1 = int'(pc1);
   end

   task automatic cmd(input int i, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp_d,
                      output logic [31:0] acc);
      bit got = 0;
      rd[i] = r; wr[i] = w; addr[i] = wa(a); wdata[i] = d; be[i] = b;
      acc = '0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (!wreq[i]) begin got = 1; acc = cyc; end
      end
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL accept_timeout dut%0d: waitrequest still 1 after 40 cycles, expected 0", i);
      end else if (r && !w) begin
         if (i == 0) q0.push_back('{exp_d, acc + 32'd3});
         else        q1.push_back('{exp_d, acc + 32'd8});
      end
      @(posedge clk); #1;
      rd[i] = 1'b0; wr[i] = 1'b0;
   endtask

   task automatic wr_word(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      logic [31:0] acc;
      cmd(i, 1'b0, 1'b1, a, d, b, 32'h0, acc);
   endtask

   task automatic rd_word(input int i, input logic [31:0] a, input logic [31:0] exp_d, output logic [31:0] acc);
      cmd(i, 1'b1, 1'b0, a, 32'h0, 4'h0, exp_d, acc);
   endtask

   task automatic drain(input int i);
      for (int k = 0; k < 60 && ((i == 0) ? q0.size() : q1.size()) != 0; k++) @(negedge clk);
      if (((i == 0) ? q0.size() : q1.size()) != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout dut%0d: responses still outstanding, expected none", i);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] acc, acc_c;
      int          snap;

      // Reset both instances for one cycle and check reset values.
      @(posedge clk); #1;
      rst_n = 2'b11;
      @(negedge clk);
      check("rst_wreq0", 32'(wreq0), 32'd1);
      check("rst_rdv0", 32'(rdv0), 32'd0);
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_err0", 32'(err0), 32'd0);
      check("rst_pc0", 32'(pc0), 32'd0);
      check("rst_wreq1", 32'(wreq1), 32'd1);
      check("rst_pc1", 32'(pc1), 32'd0);
      @(posedge clk); #1;

      // Basic write then read, latency 3.
      wr_word(0, 32'h08000000, 32'hF00BF00B, 4'hF);
      rd_word(0, 32'h08000000, 32'hF00BF00B, acc);
      drain(0);
      check("err0_clean", 32'(err0), 32'd0);
      wait_cycles(2);
      check("rdata0_hold", rdata0, 32'hF00BF00B);

      // Partial byte-enable write.
      wr_word(0, 32'h08000000, 32'h12345678, 4'b0011);
      rd_word(0, 32'h08000000, 32'hF00B5678, acc);
      drain(0);
      check("err0_after_be", 32'(err0), 32'd0);

      // read+write together: write only, no response, err set.
      snap = rdv_cnt0;
      cmd(0, 1'b1, 1'b1, 32'h08000004, 32'hDEADF00B, 4'hF, 32'h0, acc);
      wait_cycles(6);
      check("rw_no_rdv", 32'(rdv_cnt0), 32'(snap));
      check("rw_err0", 32'(err0), 32'd1);
      check("rw_pc0", 32'(pc0), 32'd0);
      rd_word(0, 32'h08000004, 32'hDEADF00B, acc);
      drain(0);

      // Out-of-range write must not alias onto word 0; out-of-range read returns the poison word.
      wr_word(0, 32'h08000100, 32'hDEADBEEF, 4'hF);
      rd_word(0, 32'h08000000, 32'hF00B5678, acc);
      rd_word(0, 32'h08000100, 32'hBAD0BAD0, acc);
      drain(0);
      check("end_pc0", 32'(pc0), 32'd0);

      // Back-pressure on dut1: three back-to-back reads with two slots.
      wr_word(1, 32'h08000000, 32'hF00B5678, 4'hF);
      wr_word(1, 32'h08000004, 32'h11111111, 4'hF);
      wr_word(1, 32'h08000008, 32'h22222222, 4'hF);
      max_pc1 = 0;
      arm1 = 1;
      rd_word(1, 32'h08000000, 32'hF00B5678, acc);
      rd_word(1, 32'h08000004, 32'h11111111, acc);
      rd_word(1, 32'h08000008, 32'h22222222, acc_c);
      drain(1);
      check("bp_third_after_first_rdv", 32'(acc_c > first_rdv1 && acc_c <= first_rdv1 + 32'd2), 32'd1);
      check("bp_pending_peak", 32'(max_pc1), 32'd2);
      check("bp_err1", 32'(err1), 32'd0);

      // Reset with two reads in flight: no responses afterwards, memory kept.
      rd_word(1, 32'h08000000, 32'hF00B5678, acc);
      rd_word(1, 32'h08000004, 32'h11111111, acc);
      check("pre_rst_pc1", 32'(pc1), 32'd2);
      rst_n[1] = 1'b0;
      q1.delete();
      @(posedge clk); #1;
      rst_n[1] = 1'b1;
      snap = rdv_cnt1;
      @(negedge clk);
      check("midrst_pc1", 32'(pc1), 32'd0);
      check("midrst_wreq1", 32'(wreq1), 32'd1);
      wait_cycles(12);
      check("midrst_no_rdv", 32'(rdv_cnt1), 32'(snap));
      rd_word(1, 32'h08000000, 32'hF00B5678, acc);
      drain(1);
      check("post_rst_err1", 32'(err1), 32'd0);

      // Out-of-range read alone sets err.
      rd_word(1, 32'h08000100, 32'hBAD0BAD0, acc);
      drain(1);
      check("oor_read_err1", 32'(err1), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
